// File: rtl/load_store_unit_if.sv
// Core request/response and word-wide data-memory signals of the load/store unit.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// rsp_valid is a one-cycle completion pulse with no back-pressure.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them down.
module load_store_unit (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {IDLE, READ, LDRESP, MERGE, WRITE, ERR} state_e;

  state_e      state, state_nxt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        reject;
  logic [31:0] addr_eff;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] merged;

  assign accept    = bus.req_valid && (state == IDLE);
  assign dbg_state = state;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (bus.req_we)
      illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    else
      illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign reject   = illegal || misaligned;
  assign addr_eff = bus.req_addr;
`else
  assign reject = illegal;
  // Halfwords drop bit 0, words drop bits [1:0]; byte accesses are never misaligned.
  always_comb begin
    addr_eff = bus.req_addr;
    if (misaligned)
      addr_eff[1:0] = {bus.req_funct3[1] ? 1'b0 : bus.req_addr[1], 1'b0};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
    end else if (accept) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      addr_q   <= addr_eff;
      wdata_q  <= bus.req_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reject)                                     state_nxt = ERR;
          else if (bus.req_we && bus.req_funct3 == 3'b010) state_nxt = WRITE;
          else                                            state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? MERGE : LDRESP;
      LDRESP:  state_nxt = IDLE;
      MERGE:   state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane extraction and byte/halfword insertion on the word returned by the READ cycle.
  always_comb begin
    ld_byte = 8'(bus.mem_rdata >> {addr_q[1:0], 3'b000});
    ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    merged  = bus.mem_rdata;
    if (funct3_q[0]) merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
    else             merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    bus.req_ready    = (state == IDLE);
    bus.rsp_valid    = 1'b0;
    bus.rsp_rdata    = 32'h0;
    bus.rsp_err      = 1'b0;
    bus.mem_addr     = 32'h0;
    bus.mem_r_enable = 1'b0;
    bus.mem_w_enable = 1'b0;
    bus.mem_wdata    = 32'h0;
    case (state)
      READ: begin
        bus.mem_r_enable = 1'b1;
        bus.mem_addr     = {addr_q[31:2], 2'b00};
      end
      LDRESP: begin
        bus.rsp_valid = 1'b1;
        case (funct3_q)
          3'b000:  bus.rsp_rdata = {{24{ld_byte[7]}}, ld_byte};
          3'b100:  bus.rsp_rdata = {24'h0, ld_byte};
          3'b001:  bus.rsp_rdata = {{16{ld_half[15]}}, ld_half};
          3'b101:  bus.rsp_rdata = {16'h0, ld_half};
          default: bus.rsp_rdata = bus.mem_rdata;
        endcase
      end
      MERGE: begin
        bus.mem_w_enable = 1'b1;
        bus.mem_addr     = {addr_q[31:2], 2'b00};
        bus.mem_wdata    = merged;
        bus.rsp_valid    = 1'b1;
      end
      WRITE: begin
        bus.mem_w_enable = 1'b1;
        bus.mem_addr     = {addr_q[31:2], 2'b00};
        bus.mem_wdata    = wdata_q;
        bus.rsp_valid    = 1'b1;
      end
      ERR: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit against a byte-addressed memory model.
module tb_load_store_unit;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- word memory the DUT talks to ----------------
  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en)                 mem[pl_idx] <= pl_data;
    else if (bus.mem_w_enable) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    if (bus.mem_r_enable)      bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  // ---------------- reference model: flat byte array ----------------
  logic [7:0] ref_mem [0:1023] = '{default: 8'h0};
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {ref_mem[b + 10'd3], ref_mem[b + 10'd2], ref_mem[b + 10'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] ea);
    int size;
    logic [31:0] v;
    size = acc_size(f3);
    v = 32'h0;
    for (int i = 0; i < size; i++) v |= 32'(ref_mem[ea[9:0] + 10'(i)]) << (8 * i);
    if (!f3[2] && size < 4 && v[8 * size - 1]) v |= 32'hFFFF_FFFF << (8 * size);
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] wd);
    for (int i = 0; i < acc_size(f3); i++) ref_mem[ea[9:0] + 10'(i)] = 8'(wd >> (8 * i));
  endtask

  // Expected outcome of an access: error flag and effective (possibly aligned) address.
  task automatic model_decode(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              output logic exp_err, output logic [31:0] ea);
    logic legal, mis;
    int size;
    size  = acc_size(f3);
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = (addr % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_err = !legal || mis;
    ea      = addr;
`else
    exp_err = !legal;
    ea      = addr - (addr % size);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = addr[9:2]; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[{addr[9:2], 2'b00} + 10'(i)] = 8'(data >> (8 * i));
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.req_ready && n < 8) begin @(negedge clk); n++; end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
  endtask

  // Full access: called and returning at a negedge; checks latency, enables, data and memory.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err);
    logic        exp_err;
    logic [31:0] ea, exp_rdata;
    int          exp_lat, exp_r, exp_w, obs_lat, r_seen, w_seen;
    model_decode(we, f3, addr, exp_err, ea);
    exp_rdata = (!exp_err && !we) ? model_load(f3, ea) : 32'h0;
    exp_lat   = (exp_err || (we && f3 == 3'b010)) ? 1 : 2;
    exp_r     = (exp_err || (we && f3 == 3'b010)) ? 0 : 1;
    exp_w     = exp_err ? 0 : (we ? exp_lat : 0);
    rdata = 32'h0; err = 1'b0;
    wait_ready();
    drive_req(we, f3, addr, wdata);
    @(negedge clk);
    bus.req_valid = 1'b0;
    drive_req(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    bus.req_valid = 1'b0;
    obs_lat = 0; r_seen = 0; w_seen = 0;
    for (int c = 1; c <= 4 && obs_lat == 0; c++) begin
      chk("rw_exclusive", 32'(bus.mem_r_enable && bus.mem_w_enable), 32'd0);
      chk("ready_busy", 32'(bus.req_ready), 32'd0);
      if (bus.mem_r_enable) begin
        r_seen = c;
        chk("rd_addr", bus.mem_addr, {ea[31:2], 2'b00});
      end
      if (bus.mem_w_enable) begin
        w_seen = c;
        chk("wr_addr", bus.mem_addr, {ea[31:2], 2'b00});
        if (f3 == 3'b010) chk("sw_wdata", bus.mem_wdata, wdata);
      end
      if (!bus.mem_r_enable && !bus.mem_w_enable)
        chk("idle_bus_zero", bus.mem_addr | bus.mem_wdata, 32'h0);
      if (bus.rsp_valid) begin
        obs_lat = c; rdata = bus.rsp_rdata; err = bus.rsp_err;
      end else begin
        @(negedge clk);
      end
    end
    chk("rsp_latency", 32'(obs_lat), 32'(exp_lat));
    chk("rsp_err", 32'(err), 32'(exp_err));
    chk("rsp_rdata", rdata, exp_rdata);
    chk("rd_cycle", 32'(r_seen), 32'(exp_r));
    chk("wr_cycle", 32'(w_seen), 32'(exp_w));
    if (!exp_err && we) model_store(f3, ea, wdata);
    @(negedge clk);
    chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    chk("mem_word", mem[ea[9:2]], model_word(ea));
  endtask

  // ---------------- directed sequence + random phase ----------------
  logic [31:0] rd;
  logic        er;
  logic [2:0]  legal_ld [0:4] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    rst_n = 1'b0; pl_en = 1'b0; pl_idx = 8'h0; pl_data = 32'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_mem_en", 32'({bus.mem_r_enable, bus.mem_w_enable}), 32'd0);
    chk("rst_mem_addr", bus.mem_addr | bus.mem_wdata, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // SW then LW of the same word
    do_access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, rd, er);
    do_access(1'b0, 3'b010, 32'h100, 32'h0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEAD_BEEF);

    // SB into a known word, then signed/unsigned byte loads
    poke(32'h100, 32'h1122_3344);
    do_access(1'b1, 3'b000, 32'h101, 32'h0000_00AA, rd, er);
    chk("sb_word", mem[8'h40], 32'h1122_AA44);
    do_access(1'b0, 3'b000, 32'h101, 32'h0, rd, er);
    chk("lb_sext", rd, 32'hFFFF_FFAA);
    do_access(1'b0, 3'b100, 32'h101, 32'h0, rd, er);
    chk("lbu_zext", rd, 32'h0000_00AA);

    // SH into a zero word, then signed/unsigned halfword loads
    poke(32'h100, 32'h0);
    do_access(1'b1, 3'b001, 32'h102, 32'h0000_8001, rd, er);
    chk("sh_word", mem[8'h40], 32'h8001_0000);
    do_access(1'b0, 3'b001, 32'h102, 32'h0, rd, er);
    chk("lh_sext", rd, 32'hFFFF_8001);
    do_access(1'b0, 3'b101, 32'h102, 32'h0, rd, er);
    chk("lhu_zext", rd, 32'h0000_8001);

    // Misaligned word load
    do_access(1'b0, 3'b010, 32'h103, 32'h0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", 32'(er), 32'd1);
`else
    chk("lw_mis_data", rd, 32'h8001_0000);
`endif

    // Illegal load and store encodings
    do_access(1'b0, 3'b111, 32'h100, 32'h0, rd, er);
    chk("ld_f3_111_err", 32'(er), 32'd1);
    do_access(1'b1, 3'b011, 32'h100, 32'h1234_5678, rd, er);
    chk("st_f3_011_err", 32'(er), 32'd1);

    // Request held valid across an SB: not accepted until the unit is back in IDLE
    poke(32'h104, 32'hA0B0_C0D0);
    wait_ready();
    drive_req(1'b1, 3'b000, 32'h104, 32'h0000_005A);
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h104, 32'h0);
    chk("hold_ready_c1", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("hold_ready_c2", 32'(bus.req_ready), 32'd0);
    chk("hold_merge_rsp", 32'(bus.rsp_valid), 32'd1);
    model_store(3'b000, 32'h104, 32'h5A);
    @(negedge clk);
    chk("hold_ready_c3", 32'(bus.req_ready), 32'd1);
    chk("hold_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("hold_accepted", 32'(bus.mem_r_enable), 32'd1);
    @(negedge clk);
    chk("hold_lw_valid", 32'(bus.rsp_valid), 32'd1);
    chk("hold_lw_data", bus.rsp_rdata, 32'hA0B0_C05A);
    chk("hold_lw_model", bus.rsp_rdata, model_load(3'b010, 32'h104));
    @(negedge clk);

    // Reset during MERGE of SB 0x200 aborts the write
    poke(32'h200, 32'h5566_7788);
    wait_ready();
    drive_req(1'b1, 3'b000, 32'h200, 32'h0000_0099);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_w_en", 32'(bus.mem_w_enable), 32'd0);
    chk("abort_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_rsp_rel", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_rsp_after", 32'(bus.rsp_valid), 32'd0);
    chk("abort_mem", mem[8'h80], 32'h5566_7788);

    // Randomized accesses, mostly legal encodings
    for (int t = 0; t < 60; t++) begin
      logic        we;
      logic [2:0]  f3;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = legal_ld[$urandom_range(0, 4)];
      do_access(we, f3, 32'($urandom_range(0, 1023)), $urandom, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so a stuck DUT still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port req_valid, input, 1 bit: the core presents an access.
REQ-004 The block SHALL have the port req_ready, output, 1 bit: high only in IDLE; the request is accepted on an edge where req_valid&&req_ready.
REQ-005 The block SHALL have the port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have the port req_funct3, input, 3 bits: RV32I width/sign code.
REQ-007 The block SHALL have the port req_addr, input, 32 bits: byte address.
REQ-008 The block SHALL have the port req_wdata, input, 32 bits: store data, right-aligned.
REQ-009 The block SHALL have the port rsp_valid, output, 1 bit: one-cycle completion pulse; no back-pressure.
REQ-010 The block SHALL have the port rsp_rdata, output, 32 bits: extended load data; 0 when rsp_valid=0 or the access is a store.
REQ-011 The block SHALL have the port rsp_err, output, 1 bit: the access was rejected; qualified by rsp_valid.
REQ-012 The block SHALL have the ports mem_addr (output, 32 bits), mem_r_enable (output, 1 bit), mem_w_enable (output, 1 bit), mem_wdata (output, 32 bits): drive the word-wide data memory, which reads and writes whole words at mem_addr[31:2].
REQ-013 The block SHALL have the port mem_rdata, input, 32 bits: memory read data, valid the cycle after mem_r_enable.

Function
REQ-014 The block SHALL implement the FSM states IDLE, READ, LDRESP, MERGE, WRITE, ERR.
REQ-015 The IDLE transitions SHALL be, on accept: LW/LH/LHU/LB/LBU -> READ; SB/SH -> READ; SW -> WRITE; illegal or rejected -> ERR.
REQ-016 The block SHALL latch req_we, req_funct3, req_addr and req_wdata on accept, and SHALL ignore request inputs outside IDLE.
REQ-017 In READ the block SHALL drive mem_r_enable=1 and mem_addr={addr[31:2],2'b00}; the next state SHALL be LDRESP for a load and MERGE for SB/SH.
REQ-018 In LDRESP the block SHALL drive rsp_valid=1 and rsp_rdata from mem_rdata: select the byte by addr[1:0] or the halfword by addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. The next state SHALL be IDLE.
REQ-019 In MERGE the block SHALL drive mem_w_enable=1 and mem_wdata = mem_rdata with the addressed byte or halfword replaced by req_wdata[7:0] or [15:0]; it SHALL drive rsp_valid=1; the next state SHALL be IDLE.
REQ-020 In WRITE the block SHALL drive mem_w_enable=1, mem_wdata=req_wdata and rsp_valid=1; the next state SHALL be IDLE.
REQ-021 In ERR the block SHALL drive rsp_valid=1, rsp_err=1 and no memory enables; the next state SHALL be IDLE.
REQ-022 mem_r_enable and mem_w_enable SHALL never be high in the same cycle; both SHALL be 0 in IDLE and ERR.
REQ-023 Measured from the accept edge, rsp_valid SHALL assert in cycle 2 for loads, cycle 2 for SB/SH, cycle 1 for SW and cycle 1 for errors.
REQ-024 Throughput SHALL be 1 access per 2 or 3 cycles, since req_ready is low from accept until the block returns to IDLE.
REQ-025 Illegal funct3 values SHALL be rejected via ERR: loads 011, 110, 111; stores 1xx and 011.
REQ-026 mem_addr and mem_wdata SHALL be 0 in any state that drives no memory enable.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force IDLE, clear latched request fields and drive all outputs to 0 except req_ready, which SHALL be 1 once the block is in IDLE.
REQ-028 Reset asserted during READ or MERGE SHALL abort the access: any memory write not yet clocked SHALL be lost, and no rsp_valid SHALL be produced.

Configuration
REQ-029 The macro LSU_MISALIGN_TRAP_EN SHALL control handling of misaligned accesses (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0).
REQ-030 With LSU_MISALIGN_TRAP_EN defined, a misaligned access SHALL go to ERR and memory SHALL NOT be touched.
REQ-031 Without LSU_MISALIGN_TRAP_EN, a misaligned access SHALL force the offending low address bits to 0 and proceed normally, and rsp_err SHALL be driven only for illegal funct3.

Verification
REQ-032 Verification SHALL cover: SW addr=0x100 wdata=0xDEADBEEF -> mem_w_enable in cycle 1, rsp_valid in cycle 1; then LW 0x100 -> rsp_rdata=0xDEADBEEF in cycle 2.
REQ-033 Verification SHALL cover: SB addr=0x101 wdata=0x000000AA onto word 0x11223344 -> memory word becomes 0x1122AA44; then LB 0x101 -> 0xFFFFFFAA and LBU 0x101 -> 0x000000AA.
REQ-034 Verification SHALL cover: SH addr=0x102 wdata=0x8001 onto 0x00000000 -> word 0x80010000; then LH 0x102 -> 0xFFFF8001 and LHU 0x102 -> 0x00008001.
REQ-035 Verification SHALL cover: LW addr=0x103 -> with LSU_MISALIGN_TRAP_EN defined, rsp_err=1 in cycle 1 and no enables; without it, the word at 0x100 is returned.
REQ-036 Verification SHALL cover: load funct3=3'b111 -> rsp_err=1 in cycle 1; a req_valid held high during MERGE is not accepted until IDLE.
REQ-037 Verification SHALL cover: rst_n low in the MERGE cycle of SB 0x200 -> memory word unchanged, rsp_valid stays 0, and req_ready=1 one cycle after release.
